// File: rtl/soc_prio_int_ctl_if.sv
// SoC_MemBus: simple single-beat register access bus.
//   req    : access strobe, one cycle per access
//   we     : 1 = write, 0 = read
//   addr   : word address bits [11:2]; [11:4] register index, [3:2] access type
//   wdata  : write data
//   rdata  : read data, valid while rvalid is high
//   rvalid : read data strobe, returned a fixed latency after a read request
interface SoC_MemBus;
  logic        req;
  logic        we;
  logic [11:2] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid;

  modport Master (output req, we, addr, wdata, input rdata, rvalid);
  modport Slave  (input req, we, addr, wdata, output rdata, rvalid);
endinterface

// File: rtl/soc_prio_int_ctl.sv
// soc_prio_int_ctl: priority-based interrupt controller with per-source
// edge/level mode, software-set pending, priority threshold, claim/complete
// in-service tracking with priority nesting, and a registered
// request/acknowledge handshake to the core.
//
// Ports:
//   clk          : system clock
//   res          : synchronous active-high reset
//   int_triggers : interrupt source lines, synchronous to clk
//   mem_bus      : register access (SoC_MemBus slave)
//   irq_valid    : interrupt offered to the core
//   irq_id       : source index offered
//   irq_ack      : core claims the offered irq_id
module soc_prio_int_ctl #(
  parameter int BUS_LATENCY = 1,
  parameter int NUM_INTS    = 32,
  parameter int PRIO_BITS   = 2
) (
  input  logic                clk,
  input  logic                res,
  input  logic [NUM_INTS-1:0] int_triggers,
  SoC_MemBus.Slave            mem_bus,
  output logic                irq_valid,
  output logic [4:0]          irq_id,
  input  logic                irq_ack
);

  // Bits of implemented sources; everything above stays zero.
  localparam logic [31:0] SRC_MASK = (NUM_INTS >= 32) ? 32'hFFFF_FFFF
                                                      : ((32'd1 << NUM_INTS) - 32'd1);

  localparam logic [7:0] IDX_CONTROL   = 8'h00;
  localparam logic [7:0] IDX_ENABLE    = 8'h01;
  localparam logic [7:0] IDX_MODE      = 8'h02;
  localparam logic [7:0] IDX_PENDING   = 8'h03;
  localparam logic [7:0] IDX_PRIO0     = 8'h04;
  localparam logic [7:0] IDX_PRIO1     = 8'h05;
  localparam logic [7:0] IDX_PRIO2     = 8'h06;
  localparam logic [7:0] IDX_PRIO3     = 8'h07;
  localparam logic [7:0] IDX_INSERVICE = 8'h08;
  localparam logic [7:0] IDX_THRESHOLD = 8'h09;
  localparam logic [7:0] IDX_EOI       = 8'h0A;
  localparam logic [7:0] IDX_STATUS    = 8'h0B;

  localparam logic [1:0] OP_MAIN = 2'd0;
  localparam logic [1:0] OP_SET  = 2'd1;
  localparam logic [1:0] OP_CLR  = 2'd2;
  localparam logic [1:0] OP_INV  = 2'd3;

  // Read-modify-write combination selected by the access type.
  function automatic logic [31:0] apply_op(input logic [31:0] cur,
                                           input logic [31:0] val,
                                           input logic [1:0]  op);
    case (op)
      OP_MAIN: apply_op = val;
      OP_SET:  apply_op = cur | val;
      OP_CLR:  apply_op = cur & ~val;
      OP_INV:  apply_op = cur ^ val;
      default: apply_op = cur;
    endcase
  endfunction

  // Registers
  logic                 gie_q, gie_d;
  logic [31:0]          enable_q, enable_d;
  logic [31:0]          mode_q, mode_d;
  logic [31:0]          pending_q, pending_d;
  logic [31:0]          inservice_q, inservice_d;
  logic [31:0]          trig_q, trig_d;
  logic [PRIO_BITS-1:0] threshold_q, threshold_d;
  logic [PRIO_BITS-1:0] prio_q [32];
  logic [PRIO_BITS-1:0] prio_d [32];
  logic                 irq_valid_q, irq_valid_d;
  logic [4:0]           irq_id_q, irq_id_d;
  logic [31:0]          rd_data_q [BUS_LATENCY];
  logic [31:0]          rd_data_d [BUS_LATENCY];
  logic [BUS_LATENCY-1:0] rd_vld_q, rd_vld_d;

  // Combinational signals
  logic                 wr_s, rd_s;
  logic [7:0]           idx_s;
  logic [1:0]           op_s;
  logic [31:0]          wdata_s;
  logic [31:0]          trig_in_s;
  logic [31:0]          prio_word_s [4];
  logic [31:0]          rd_val_s;
  logic [31:0]          wr_word_s;
  logic                 ack_take_s;
  logic [31:0]          pend_keep_s, pend_set_s;
  logic [31:0]          claim_edge_s, edge_s, pend_edge_s;
  logic [31:0]          eoi_clr_s, claim_set_s;
  logic [PRIO_BITS-1:0] max_is_s, best_prio_s;
  logic [31:0]          eligible_s;
  logic [4:0]           win_id_s;
  logic                 found_s;

  assign wr_s      = mem_bus.req & mem_bus.we;
  assign rd_s      = mem_bus.req & ~mem_bus.we;
  assign idx_s     = mem_bus.addr[11:4];
  assign op_s      = mem_bus.addr[3:2];
  assign wdata_s   = mem_bus.wdata;
  assign trig_in_s = 32'(int_triggers);

  // A claim is only honoured against an offer that is actually visible.
  assign ack_take_s = irq_valid_q & irq_ack;

  // Pack per-source priorities into the four PRIO register words.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      prio_word_s[k] = 32'd0;
      for (int j = 0; j < 8; j++) begin
        prio_word_s[k][4*j +: PRIO_BITS] = prio_q[8*k+j];
      end
    end
  end

  // Register read mux; also the "current value" for read-modify-write.
  always_comb begin
    case (idx_s)
      IDX_CONTROL:   rd_val_s = {31'd0, gie_q};
      IDX_ENABLE:    rd_val_s = enable_q;
      IDX_MODE:      rd_val_s = mode_q;
      IDX_PENDING:   rd_val_s = pending_q;
      IDX_PRIO0:     rd_val_s = prio_word_s[0];
      IDX_PRIO1:     rd_val_s = prio_word_s[1];
      IDX_PRIO2:     rd_val_s = prio_word_s[2];
      IDX_PRIO3:     rd_val_s = prio_word_s[3];
      IDX_INSERVICE: rd_val_s = inservice_q;
      IDX_THRESHOLD: rd_val_s = 32'(threshold_q);
      IDX_STATUS:    rd_val_s = {irq_valid_q, 26'd0, irq_id_q};
      default:       rd_val_s = 32'd0;
    endcase
  end

  assign wr_word_s = apply_op(rd_val_s, wdata_s, op_s);

  // Next state of plain configuration registers.
  always_comb begin
    gie_d       = (wr_s && idx_s == IDX_CONTROL)   ? wr_word_s[0]                 : gie_q;
    enable_d    = (wr_s && idx_s == IDX_ENABLE)    ? (wr_word_s & SRC_MASK)       : enable_q;
    mode_d      = (wr_s && idx_s == IDX_MODE)      ? (wr_word_s & SRC_MASK)       : mode_q;
    threshold_d = (wr_s && idx_s == IDX_THRESHOLD) ? wr_word_s[PRIO_BITS-1:0]     : threshold_q;
    for (int i = 0; i < 32; i++) begin
      prio_d[i] = (wr_s && (idx_s == (IDX_PRIO0 + 8'(i / 8))) && (i < NUM_INTS))
                  ? wr_word_s[4*(i%8) +: PRIO_BITS] : prio_q[i];
    end
  end

  // Pending: software write, then claim clear, then hardware edge (edge wins).
  // Level sources simply follow the line, one cycle behind like edges.
  always_comb begin
    pend_keep_s = 32'hFFFF_FFFF;
    pend_set_s  = 32'd0;
    if (wr_s && idx_s == IDX_PENDING) begin
      case (op_s)
        OP_MAIN: pend_keep_s = wdata_s;
        OP_SET:  pend_set_s  = wdata_s;
        OP_CLR:  pend_keep_s = ~wdata_s;
        OP_INV:  pend_keep_s = ~wdata_s;
        default: pend_keep_s = 32'hFFFF_FFFF;
      endcase
    end else begin
      pend_set_s = 32'd0;
    end
    claim_edge_s = (ack_take_s && mode_q[irq_id_q]) ? (32'd1 << irq_id_q) : 32'd0;
    edge_s       = trig_in_s & ~trig_q;
    pend_edge_s  = (((pending_q & pend_keep_s) | pend_set_s) & ~claim_edge_s) | edge_s;
    pending_d    = ((pend_edge_s & mode_q) | (trig_in_s & ~mode_q)) & SRC_MASK;
    trig_d       = trig_in_s & SRC_MASK;
  end

  // In-service: EOI clears, claim sets; a same-cycle claim of that bit wins.
  always_comb begin
    eoi_clr_s   = (wr_s && idx_s == IDX_EOI) ? (32'd1 << wdata_s[4:0]) : 32'd0;
    claim_set_s = ack_take_s ? (32'd1 << irq_id_q) : 32'd0;
    inservice_d = ((inservice_q & ~eoi_clr_s) | claim_set_s) & SRC_MASK;
  end

  // Arbitration: highest priority wins; scanning downward with >= leaves
  // the lowest index on ties.
  always_comb begin
    max_is_s = {PRIO_BITS{1'b0}};
    for (int i = 0; i < 32; i++) begin
      max_is_s = (inservice_q[i] && prio_q[i] > max_is_s) ? prio_q[i] : max_is_s;
    end
    for (int i = 0; i < 32; i++) begin
      eligible_s[i] = pending_q[i] & enable_q[i] & ~inservice_q[i] & gie_q &
                      (prio_q[i] > threshold_q) & (prio_q[i] > max_is_s);
    end
    best_prio_s = {PRIO_BITS{1'b0}};
    win_id_s    = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      win_id_s    = (eligible_s[i] && prio_q[i] >= best_prio_s) ? 5'(i)     : win_id_s;
      best_prio_s = (eligible_s[i] && prio_q[i] >= best_prio_s) ? prio_q[i] : best_prio_s;
    end
    found_s = |eligible_s;
  end

  // Offer registration; an honoured claim blanks the offer for one cycle.
  always_comb begin
    irq_valid_d = found_s & ~ack_take_s;
    irq_id_d    = win_id_s;
  end

  // Read-return pipeline, BUS_LATENCY stages deep.
  always_comb begin
    rd_data_d[0] = rd_s ? rd_val_s : 32'd0;
    rd_vld_d[0]  = rd_s;
    for (int s = 1; s < BUS_LATENCY; s++) begin
      rd_data_d[s] = rd_data_q[s-1];
      rd_vld_d[s]  = rd_vld_q[s-1];
    end
  end

  // State registers with synchronous reset; reset drops any claim in flight.
  always_ff @(posedge clk) begin
    if (res) begin
      gie_q       <= 1'b1;
      enable_q    <= 32'd0;
      mode_q      <= 32'd0;
      pending_q   <= 32'd0;
      inservice_q <= 32'd0;
      trig_q      <= 32'd0;
      threshold_q <= {PRIO_BITS{1'b0}};
      irq_valid_q <= 1'b0;
      irq_id_q    <= 5'd0;
      rd_vld_q    <= {BUS_LATENCY{1'b0}};
      for (int i = 0; i < 32; i++) begin
        prio_q[i] <= {PRIO_BITS{1'b0}};
      end
      for (int s = 0; s < BUS_LATENCY; s++) begin
        rd_data_q[s] <= 32'd0;
      end
    end else begin
      gie_q       <= gie_d;
      enable_q    <= enable_d;
      mode_q      <= mode_d;
      pending_q   <= pending_d;
      inservice_q <= inservice_d;
      trig_q      <= trig_d;
      threshold_q <= threshold_d;
      irq_valid_q <= irq_valid_d;
      irq_id_q    <= irq_id_d;
      rd_vld_q    <= rd_vld_d;
      for (int i = 0; i < 32; i++) begin
        prio_q[i] <= prio_d[i];
      end
      for (int s = 0; s < BUS_LATENCY; s++) begin
        rd_data_q[s] <= rd_data_d[s];
      end
    end
  end

  assign irq_valid      = irq_valid_q;
  assign irq_id         = irq_id_q;
  assign mem_bus.rdata  = rd_data_q[BUS_LATENCY-1];
  assign mem_bus.rvalid = rd_vld_q[BUS_LATENCY-1];

endmodule
